// File: rtl/pci_pkg.sv
// Shared PCI definitions: command codes, initiator state encoding and active-low levels.
// Used by both the initiator and the target device models.
package pci_pkg;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    localparam logic ASSERTED   = 1'b0;
    localparam logic DEASSERTED = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_TURN = 2'd3
    } pci_state_e;

    // A requested length of 0 means one phase; anything above the burst limit is capped.
    function automatic logic [2:0] clamp_len(input logic [2:0] len, input int unsigned max_burst);
        logic [2:0] w_max;
        w_max = 3'(max_burst);
        if (len == 3'd0)
            return 3'd1;
        else if (len > w_max)
            return w_max;
        else
            return len;
    endfunction

endpackage

// File: rtl/pci_initiator.sv
// PCI bus master: runs one address phase, 1..MAX_BURST data phases and a turnaround
// per accepted local request, with TRDY wait states and DEVSEL master-abort timeout.
module pci_initiator
    import pci_pkg::*;
#(
    parameter int MAX_BURST      = 4,
    parameter int DEVSEL_TIMEOUT = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [3:0]  i_req_cmd,
    input  logic [31:0] i_req_addr,
    input  logic [2:0]  i_req_len,
    input  logic [31:0] i_wr_data,
    output logic        o_wr_data_pop,
    output logic [31:0] o_rd_data,
    output logic        o_rd_valid,
    output logic        o_done,
    output logic        o_abort,
    output logic        o_frame,
    output logic        o_irdy,
    output logic [3:0]  o_cbe,
    inout  wire  [31:0] io_ad,
    input  logic        i_trdy,
    input  logic        i_devsel
);

    localparam int TO_W = $clog2(DEVSEL_TIMEOUT + 1);

    pci_state_e        r_state;
    pci_state_e        w_state_nxt;
    logic [3:0]        r_cmd;
    logic [31:0]       r_addr;
    logic [2:0]        r_remain;
    logic [TO_W-1:0]   r_to;
    logic              r_dev_seen;
    logic              r_aborted;
    logic [31:0]       r_rd_data;
    logic              r_rd_valid;

    logic              w_accept;
    logic              w_is_write;
    logic              w_timeout;
    logic              w_xfer;
    logic              w_ad_oe;
    logic [31:0]       w_ad_val;
    logic              w_cbe_oe;
    logic [3:0]        w_cbe_val;

    assign w_accept   = (r_state == ST_IDLE) && i_req_valid;
    assign w_is_write = (r_cmd == CMD_MEM_WRITE);
    // Timeout only advances until the first DEVSEL; a later DEVSEL drop never restarts it.
    assign w_timeout  = (r_state == ST_DATA) && !r_dev_seen && (i_devsel == DEASSERTED) &&
                        (r_to == TO_W'(DEVSEL_TIMEOUT - 1));
    assign w_xfer     = (r_state == ST_DATA) && (i_trdy == ASSERTED) && !w_timeout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_ADDR;
            ST_ADDR: w_state_nxt = ST_DATA;
            ST_DATA: begin
                if (w_timeout)
                    w_state_nxt = ST_TURN;
                else if (w_xfer && (r_remain == 3'd1))
                    w_state_nxt = ST_TURN;
            end
            ST_TURN: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready   = 1'b0;
        o_frame       = DEASSERTED;
        o_irdy        = DEASSERTED;
        o_done        = 1'b0;
        o_abort       = 1'b0;
        o_wr_data_pop = 1'b0;
        w_ad_oe       = 1'b0;
        w_ad_val      = i_wr_data;
        w_cbe_oe      = 1'b0;
        w_cbe_val     = 4'b0000;
        case (r_state)
            ST_IDLE: o_req_ready = 1'b1;
            ST_ADDR: begin
                o_frame   = ASSERTED;
                w_ad_oe   = 1'b1;
                w_ad_val  = r_addr;
                w_cbe_oe  = 1'b1;
                w_cbe_val = r_cmd;
            end
            ST_DATA: begin
                o_frame       = (r_remain > 3'd1) ? ASSERTED : DEASSERTED;
                o_irdy        = ASSERTED;
                w_cbe_oe      = 1'b1;
                w_ad_oe       = w_is_write;
                o_wr_data_pop = w_is_write && w_xfer;
            end
            ST_TURN: begin
                o_done  = !r_aborted;
                o_abort = r_aborted;
            end
            default: ;
        endcase
    end

    assign io_ad      = w_ad_oe  ? w_ad_val  : 32'bz;
    assign o_cbe      = w_cbe_oe ? w_cbe_val : 4'bz;
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd      <= 4'b0000;
            r_addr     <= 32'h0;
            r_remain   <= 3'd0;
            r_to       <= '0;
            r_dev_seen <= 1'b0;
            r_aborted  <= 1'b0;
            r_rd_data  <= 32'h0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_xfer && !w_is_write;
            if (w_xfer && !w_is_write)
                r_rd_data <= io_ad;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd      <= i_req_cmd;
                        r_addr     <= i_req_addr;
                        r_remain   <= clamp_len(i_req_len, MAX_BURST);
                        r_to       <= '0;
                        r_dev_seen <= 1'b0;
                        r_aborted  <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (i_devsel == ASSERTED)
                        r_dev_seen <= 1'b1;
                    else if (!r_dev_seen)
                        r_to <= r_to + TO_W'(1);
                    if (w_timeout)
                        r_aborted <= 1'b1;
                    if (w_xfer)
                        r_remain <= r_remain - 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/pci_initiator.md
# pci_initiator

Bus-master (initiator) side of the team's PCI interface: accepts a memory read or write request from local logic and runs a complete PCI transaction (address phase, 1..MAX_BURST data phases, turnaround) against a `Device_new`-style target. Sits between the local request logic and the shared PCI bus. It handles target wait states via TRDY and ends a transaction with a master abort when no DEVSEL arrives.

## Interface
- MAX_BURST, 4: maximum data phases per transaction (REQ_LEN upper bound).
- DEVSEL_TIMEOUT, 5: DATA-state clocks without DEVSEL before master abort.
- CLK  in  1  bus clock; all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  local request present.
- REQ_READY  out  1  high only in IDLE; a request is accepted on an edge with both high.
- REQ_CMD  in  4  PCI command; 4'b0110 memory read, 4'b0111 memory write.
- REQ_ADDR  in  32  target address.
- REQ_LEN  in  3  data phases, 1..MAX_BURST; 0 is treated as 1 and values above MAX_BURST as MAX_BURST.
- WR_DATA  in  32  show-ahead write word for the current data phase.
- WR_DATA_POP  out  1  combinational; high in a write data phase when IRDY=0 and TRDY=0.
- RD_DATA  out  32  last word read.
- RD_VALID  out  1  one-cycle pulse; RD_DATA holds a new word.
- DONE  out  1  one-cycle pulse in TURN after a normal completion.
- ABORT  out  1  one-cycle pulse in TURN after a master abort.
- FRAME  out  1  active-low PCI FRAME#.
- IRDY  out  1  active-low PCI IRDY#.
- CBE  out  4  command/byte enables; Z when not owning the bus.
- AD  inout  32  multiplexed address/data bus.
- TRDY  in  1  active-low target ready.
- DEVSEL  in  1  active-low device select.

## Operation
- States: IDLE, ADDR, DATA, TURN.
- IDLE: FRAME=1, IRDY=1, AD=Z, CBE=Z, REQ_READY=1. On accept, latch cmd, address and length, then go to ADDR.
- ADDR (1 clk): FRAME=0, IRDY=1, AD=latched address, CBE=latched command. Go to DATA.
- DATA: IRDY=0, CBE=4'b0000. Writes drive AD=WR_DATA; reads release AD=Z (turnaround).
- DATA FRAME value: 0 while remaining phases > 1, 1 during the final phase. With REQ_LEN=1, FRAME=1 from the first DATA clock.
- Transfer: on a rising edge with IRDY=0 and TRDY=0.
  - Write: WR_DATA_POP is high in that cycle.
  - Read: RD_DATA<=AD and RD_VALID pulses the next cycle.
  - The remaining-phase counter decrements. If it was the last phase, go to TURN.
- TRDY=1 inserts wait states: the bus holds and nothing is counted or popped.
- Master abort: a timeout counter runs in DATA while DEVSEL=1 and stops once DEVSEL=0 is seen. When it reaches DEVSEL_TIMEOUT, go to TURN, pulse ABORT, and produce no RD_VALID or WR_DATA_POP.
- TURN (1 clk): FRAME=1, IRDY=1, AD=Z, CBE=Z. DONE or ABORT pulses. Always go to IDLE.

## Timing
- Reset values: FRAME=1, IRDY=1, AD=Z, CBE=Z, REQ_READY=1, RD_DATA=0, RD_VALID=0, DONE=0, ABORT=0, WR_DATA_POP=0, state IDLE.
- Zero-wait transaction of N phases: accept edge, 1 ADDR clk, N DATA clks, 1 TURN clk. Next accept is possible at the edge after TURN, so back-to-back transactions are 3+N clocks apart.
- All bus outputs are registered from the state, except AD, which is muxed from the state and WR_DATA.
- REQ_VALID while not in IDLE is ignored.
- RST low at any time: the bus is released immediately (async), and all counters and pulses clear.
- DEVSEL seen low then high again later does not restart the timeout.

## Structure
- Shared `pci_pkg` holds:
  - command constants CMD_MEM_READ=4'b0110 and CMD_MEM_WRITE=4'b0111;
  - the state encoding;
  - active-low level constants ASSERTED=1'b0 and DEASSERTED=1'b1, shared with the target device.
- Single module. No sub-module is needed; the abort counter is inline.

## Test plan
- Single write: addr 32'h0000_FFFF, data 32'h0000_F0F0, target TRDY=0 and DEVSEL=0 immediately.
  - AD shows the address with CBE=0111 for 1 clk, then the data with FRAME=1 and IRDY=0.
  - One WR_DATA_POP, DONE in TURN.
- Single read: addr 32'h0000_FFFF, target drives 32'hDEAD_BEEF.
  - AD=Z in DATA; RD_DATA=32'hDEAD_BEEF with one RD_VALID pulse; DONE.
- Burst write, REQ_LEN=3, target inserts 2 TRDY wait states on phase 2.
  - Exactly 3 WR_DATA_POP pulses.
  - FRAME rises only in phase 3; 7 clocks from accept to IDLE.
- Master abort: DEVSEL held 1 on a read.
  - ABORT pulses after 5 DATA clocks; no RD_VALID; bus idle next cycle.
- Back-to-back write then read with REQ_VALID held high: second ADDR phase starts exactly 1 clk after TURN.
- RST low mid-burst (phase 2 of 4): FRAME=1, IRDY=1, AD=Z, CBE=Z immediately; REQ_READY=1 after release.
